// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with thresholds, sticky error flags and read-valid strobe.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AFULL_TH  = 56,
  parameter int AEMPTY_TH = 8
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_CNT   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT   = AEMPTY_TH[ADDR_W:0];
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow, r_underflow;
  logic              w_wr, w_rd;
  assign w_wr = bus.wr_en && !bus.full;
  assign w_rd = bus.rd_en && !bus.empty;
  assign bus.count        = r_count;
  assign bus.full         = r_count == FULL_CNT;
  assign bus.empty        = r_count == '0;
  assign bus.almost_full  = r_count >= AF_CNT;
  assign bus.almost_empty = r_count <= AE_CNT;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + ADDR_W'(w_wr);
      r_rd_ptr    <= r_rd_ptr + ADDR_W'(w_rd);
      r_count     <= r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_rd);
      // a new error event outranks a same-cycle clear
      r_overflow  <= (bus.wr_en && bus.full) || (r_overflow && !bus.clr_err);
      r_underflow <= (bus.rd_en && bus.empty) || (r_underflow && !bus.clr_err);
    end
`ifdef SYNC_FIFO_FWFT_EN
  // masked while empty so unwritten memory never reaches the output
  assign bus.rd_data  = bus.empty ? '0 : r_mem[r_rd_ptr];
  assign bus.rd_valid = !bus.empty;
`else
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
    end
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (both read modes)
module tb_sync_fifo_param;
  logic clk, rst;
  int   n_chk, n_err;
  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(6)) bus();
  sync_fifo_param #(.DATA_W(8), .ADDR_W(6), .AFULL_TH(56), .AEMPTY_TH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask
  task automatic pop(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("pop_data", 32'(bus.rd_data), 32'(exp));
    chk("pop_valid", 32'(bus.rd_valid), 1);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
`else
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("pop_data", 32'(bus.rd_data), 32'(exp));
    chk("pop_valid", 32'(bus.rd_valid), 1);
`endif
  endtask
  task automatic chk_reset;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    #12;
    chk_reset();
    rst = 1'b0;
    // underflow on empty, then clear
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_count", 32'(bus.count), 0);
    chk("unf_rd_data", 32'(bus.rd_data), 0);
    chk("unf_rd_valid", 32'(bus.rd_valid), 0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("unf_clr", 32'(bus.underflow), 0);
    // fill 0x00..0x3F with threshold checks
    for (int i = 0; i < 64; i++) begin
      push(8'(i));
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_aempty", 32'(bus.almost_empty), 32'(i + 1 <= 8));
      chk("fill_afull", 32'(bus.almost_full), 32'(i + 1 >= 56));
      chk("fill_full", 32'(bus.full), 32'(i + 1 == 64));
    end
    push(8'hAA);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 64);
    // drain in order
    for (int i = 0; i < 64; i++) pop(8'(i));
    chk("drain_empty", 32'(bus.empty), 1);
    step();
    chk("idle_valid", 32'(bus.rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("idle_hold", 32'(bus.rd_data), 32'h3F);
`endif
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 0);
    // sustained simultaneous traffic across pointer wrap
    for (int i = 0; i < 10; i++) push(8'(i));
    for (int i = 0; i < 200; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i + 10);
      bus.rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      chk("stream_data", 32'(bus.rd_data), 32'(i));
      step();
`else
      step();
      chk("stream_data", 32'(bus.rd_data), 32'(i));
`endif
      chk("stream_count", 32'(bus.count), 10);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    for (int i = 200; i < 210; i++) pop(8'(i));
    chk("stream_empty", 32'(bus.empty), 1);
    chk("stream_unf", 32'(bus.underflow), 0);
    // full with simultaneous write+read: write dropped
    for (int i = 0; i < 64; i++) push(8'(i + 100));
    chk("full2", 32'(bus.full), 1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hBB;
    bus.rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chk("fullrw_data", 32'(bus.rd_data), 100);
    step();
`else
    step();
    chk("fullrw_data", 32'(bus.rd_data), 100);
`endif
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("fullrw_count", 32'(bus.count), 63);
    chk("fullrw_ovf", 32'(bus.overflow), 1);
    for (int i = 1; i < 64; i++) pop(8'(i + 100));
    chk("fullrw_empty", 32'(bus.empty), 1);
    // asynchronous reset mid-burst
    for (int i = 0; i < 20; i++) push(8'(i));
    chk("pre_rst_count", 32'(bus.count), 20);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h77;
    rst = 1'b1;
    #1;
    chk_reset();
    bus.wr_en = 1'b0;
    step();
    rst = 1'b0;
    chk_reset();
    // single write into empty FIFO, no read request
    push(8'h5A);
    chk("one_count", 32'(bus.count), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_data", 32'(bus.rd_data), 32'h5A);
    chk("fwft_valid", 32'(bus.rd_valid), 1);
`else
    chk("std_data", 32'(bus.rd_data), 0);
    chk("std_valid", 32'(bus.rd_valid), 0);
`endif
    pop(8'h5A);
    chk("final_empty", 32'(bus.empty), 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
